// File: rtl/sad_block_fetch_pkg.sv
// Shared constants for the SAD feeder, the SAD stage and the frame controller.
// Holds the FSM encoding, block geometry and bus layout types.
package sad_block_fetch_pkg;

    localparam int BLK    = 4;
    localparam int NTERMS = BLK * BLK;
    localparam int PIX_W  = 8;
    localparam int TERM_W = 32;
    localparam int BUS_W  = NTERMS * TERM_W;
    localparam int CUR_W  = NTERMS * PIX_W;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_EMIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef logic [NTERMS-1:0][TERM_W-1:0] ad_vec_t;
    typedef logic [NTERMS-1:0][PIX_W-1:0]  cur_blk_t;

endpackage

// File: rtl/sad_absdiff8.sv
// Unsigned |a-b| on one pixel pair, zero-extended to a SAD term.
// The difference is taken on PIX_W+1 signed bits so 0-255 never wraps.
module sad_absdiff8
    import sad_block_fetch_pkg::*;
(
    input  logic [PIX_W-1:0]  a,
    input  logic [PIX_W-1:0]  b,
    output logic [TERM_W-1:0] y
);

    logic signed [PIX_W:0] diff;
    logic signed [PIX_W:0] mag;

    // Signed subtract, then fold negative results back to magnitude.
    always_comb begin
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        mag  = diff[PIX_W] ? -diff : diff;
        y    = TERM_W'($unsigned(mag));
    end

endmodule

// File: rtl/sad_block_fetch.sv
// Scans every 4x4 candidate of the reference frame and feeds the SAD stage.
// Fetches 16 pixels per candidate, then presents abs diffs with row/col.
module sad_block_fetch
    import sad_block_fetch_pkg::*;
#(
    parameter int FRAME_W = 64,
    parameter int FRAME_H = 64,
    parameter int ADDR_W  = 12
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic [CUR_W-1:0]  cur_pix,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [BUS_W-1:0]  ad_bus,
    output logic [31:0]       row_out,
    output logic [31:0]       col_out,
    output logic              sad_valid,
    output logic              busy,
    output logic              done
);

    localparam int RC_W = $clog2((FRAME_W > FRAME_H) ? FRAME_W : FRAME_H);
    localparam logic [RC_W-1:0] COL_LAST = RC_W'(FRAME_W - BLK);
    localparam logic [RC_W-1:0] ROW_LAST = RC_W'(FRAME_H - BLK);

    logic [2:0]      state_q, state_d;
    logic [3:0]      k_q, k_d;
    logic [RC_W-1:0] row_q, row_d;
    logic [RC_W-1:0] col_q, col_d;
    cur_blk_t        cur_q, cur_d;
    ad_vec_t         stage_q, stage_d;
    ad_vec_t         ad_q, ad_d;
    logic [RC_W-1:0] row_out_q, row_out_d;
    logic [RC_W-1:0] col_out_q, col_out_d;
    logic            sad_valid_q, sad_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [3:0]        cap_idx;
    logic [TERM_W-1:0] cap_term;
    logic [ADDR_W-1:0] row_a;
    logic [ADDR_W-1:0] col_a;

    // Term whose read data is on mem_rdata this cycle (one behind the fetch).
    always_comb begin
        cap_idx = (state_q == ST_DRAIN) ? 4'd15 : k_q - 4'd1;
    end

    sad_absdiff8 u_absdiff (
        .a (mem_rdata),
        .b (cur_q[cap_idx]),
        .y (cap_term)
    );

    // Read strobe and row-major address of term k of the current candidate.
    always_comb begin
        row_a     = ADDR_W'(row_q) + ADDR_W'(k_q[3:2]);
        col_a     = ADDR_W'(col_q) + ADDR_W'(k_q[1:0]);
        mem_rd_en = (state_q == ST_FETCH);
        mem_addr  = mem_rd_en ? row_a * ADDR_W'(FRAME_W) + col_a : '0;
    end

    // Scan sequencing, term capture and output presentation.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        row_d       = row_q;
        col_d       = col_q;
        cur_d       = cur_q;
        stage_d     = stage_q;
        ad_d        = ad_q;
        row_out_d   = row_out_q;
        col_out_d   = col_out_q;
        sad_valid_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_d   = cur_pix;
                    busy_d  = 1'b1;
                    k_d     = 4'd0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (k_q != 4'd0) begin
                    stage_d[cap_idx] = cap_term;
                end
                k_d = k_q + 4'd1;
                if (k_q == 4'd15) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                stage_d[cap_idx] = cap_term;
                k_d     = 4'd0;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                ad_d        = stage_q;
                row_out_d   = row_q;
                col_out_d   = col_q;
                sad_valid_d = 1'b1;
                state_d     = ST_FETCH;
                if (col_q == COL_LAST) begin
                    if (row_q == ROW_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        col_d = '0;
                        row_d = row_q + RC_W'(1);
                    end
                end else begin
                    col_d = col_q + RC_W'(1);
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                row_d   = '0;
                col_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any scan in progress.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            cur_q       <= '0;
            stage_q     <= '0;
            ad_q        <= '0;
            row_out_q   <= '0;
            col_out_q   <= '0;
            sad_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cur_q       <= cur_d;
            stage_q     <= stage_d;
            ad_q        <= ad_d;
            row_out_q   <= row_out_d;
            col_out_q   <= col_out_d;
            sad_valid_q <= sad_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ad_bus    = ad_q;
    assign row_out   = 32'(row_out_q);
    assign col_out   = 32'(col_out_q);
    assign sad_valid = sad_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sad_block_fetch.sv
// Scoreboard bench for sad_block_fetch: a frame/candidate model queues
// expected reads and results; a negedge monitor pops and compares.
module tb_sad_block_fetch;

    localparam int FW    = 64;
    localparam int FH    = 64;
    localparam int NC    = FW - 3;
    localparam int NCAND = NC * (FH - 3);

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] cur_pix = '0;
    logic         mem_rd_en;
    logic [11:0]  mem_addr;
    logic [7:0]   mem_rdata = '0;
    logic [511:0] ad_bus;
    logic [31:0]  row_out;
    logic [31:0]  col_out;
    logic         sad_valid;
    logic         busy;
    logic         done;

    sad_block_fetch #(
        .FRAME_W (FW),
        .FRAME_H (FH),
        .ADDR_W  (12)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start     (start),
        .cur_pix   (cur_pix),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .ad_bus    (ad_bus),
        .row_out   (row_out),
        .col_out   (col_out),
        .sad_valid (sad_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    logic [7:0] mem [0:4095];
    logic [7:0] cur_arr [16];

    always @(posedge Clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic [511:0] ad;
        int           row;
        int           col;
    } exp_t;

    exp_t exp_q[$];
    int   addr_q[$];

    int           tests = 0;
    int           fails = 0;
    int           t_start = 0;
    int           n_valid = 0;
    int           last_valid_cyc = 0;
    bit           exp_done = 0;
    bit           done_seen = 0;
    logic [511:0] last_ad = '0;
    int           last_row = 0;
    int           last_col = 0;

    task automatic chk(input string nm, input logic [511:0] got,
                       input logic [511:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Candidate i in scan order: expected reads, and optionally its result.
    task automatic push_cands(input int n_res, input int n_rd);
        for (int i = 0; i < n_rd && i < NCAND; i++) begin
            int   r;
            int   c;
            exp_t e;
            r     = i / NC;
            c     = i % NC;
            e.ad  = '0;
            e.row = r;
            e.col = c;
            for (int k = 0; k < 16; k++) begin
                int a;
                int d;
                a = (r + k / 4) * FW + c + k % 4;
                d = int'(mem[a]) - int'(cur_arr[k]);
                if (d < 0) d = -d;
                e.ad[32*k +: 32] = 32'(d);
                addr_q.push_back(a);
            end
            if (i < n_res) exp_q.push_back(e);
        end
    endtask

    // Monitor: every read, every strobe, output hold and done timing.
    always @(negedge Clk) begin
        exp_t e;
        if (!Rst) begin
            if (mem_rd_en) begin
                if (addr_q.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_addr", mem_addr, addr_q.pop_front());
            end
            if (sad_valid) begin
                n_valid++;
                chk("valid_cycle", cyc, t_start + 18 * n_valid);
                chk("valid_busy", busy, 1);
                if (exp_q.size() == 0) begin
                    chk("valid_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ad_bus", ad_bus, e.ad);
                    chk("row_out", row_out, e.row);
                    chk("col_out", col_out, e.col);
                    last_ad  = e.ad;
                    last_row = e.row;
                    last_col = e.col;
                end
                last_valid_cyc = cyc;
            end else begin
                chk("hold_ad", ad_bus, last_ad);
                chk("hold_row", row_out, last_row);
                chk("hold_col", col_out, last_col);
            end
            if (done) begin
                done_seen = 1;
                chk("done_expected", exp_done, 1);
                chk("done_timing", cyc, last_valid_cyc + 1);
                chk("done_busy", busy, 0);
                chk("done_all_emitted", exp_q.size(), 0);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        #1;
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_ad_bus", ad_bus, 0);
        chk("rst_row", row_out, 0);
        chk("rst_col", col_out, 0);
        chk("rst_valid", sad_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        exp_q.delete();
        addr_q.delete();
        last_ad  = '0;
        last_row = 0;
        last_col = 0;
        exp_done = 0;
        tick();
        tick();
        Rst = 1'b0;
        tick();
    endtask

    task automatic do_start();
        for (int k = 0; k < 16; k++) cur_pix[8*k +: 8] = cur_arr[k];
        start   = 1'b1;
        t_start = cyc + 1;
        n_valid = 0;
        tick();
        start   = 1'b0;
        cur_pix = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_valids(input int n, input int budget);
        int w;
        w = 0;
        while (n_valid < n && w < budget) begin
            tick();
            w++;
        end
        if (n_valid < n) chk("timeout_valid", n_valid, n);
    endtask

    initial begin
        int w;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        for (int k = 0; k < 16; k++) cur_arr[k] = 8'h00;
        @(posedge Clk);
        #2;
        do_reset();

        // Flat frame equal to the block: all terms zero.
        for (int i = 0; i < 4096; i++) mem[i] = 8'h10;
        for (int k = 0; k < 16; k++) cur_arr[k] = 8'h10;
        push_cands(2, 3);
        do_start();
        wait_valids(2, 60);
        do_reset();

        // Ramp frame x+y, block taken from (0,0): terms 0 then 1.
        for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++) mem[y*FW + x] = 8'(x + y);
        for (int k = 0; k < 16; k++) cur_arr[k] = mem[(k/4)*FW + k%4];
        push_cands(3, 4);
        do_start();
        wait_valids(3, 80);
        do_reset();

        // Extreme difference must give 255, never wrap.
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        for (int k = 0; k < 16; k++) cur_arr[k] = 8'hFF;
        push_cands(2, 3);
        do_start();
        wait_valids(2, 60);
        do_reset();

        // Reset in the middle of the third candidate's fetch.
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom());
        for (int k = 0; k < 16; k++) cur_arr[k] = 8'($urandom());
        push_cands(2, 3);
        do_start();
        repeat (39) tick();
        chk("valids_before_rst", n_valid, 2);
        do_reset();
        for (int k = 0; k < 16; k++) cur_arr[k] = 8'($urandom());
        push_cands(2, 3);
        do_start();
        wait_valids(2, 60);
        do_reset();

        // Full random scan with stray start pulses at cycles 5 and 100.
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom());
        for (int k = 0; k < 16; k++) cur_arr[k] = 8'($urandom());
        exp_done  = 1;
        done_seen = 0;
        push_cands(NCAND, NCAND);
        do_start();
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (94) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (!done_seen && w < 70000) begin
            tick();
            w++;
        end
        if (!done_seen) chk("timeout_done", 0, 1);
        chk("scan_count", n_valid, NCAND);
        chk("last_row", row_out, FH - 4);
        chk("last_col", col_out, FW - 4);
        chk("done_pulse_len", done, 0);
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_rd_en", mem_rd_en, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
